// File: rtl/lte_ul_tdl_agc_pwr_meas.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lte_ul_tdl_agc_pwr_meas: per-antenna windowed mean power after the UL AGC. |
// | Optional peak tracking: LTE_UL_AGC_PEAK_EN.   Revision: 1.0                |
// +----------------------------------------------------------------------------+
module lte_ul_tdl_agc_pwr_meas #(
  parameter int XNUM     = 8,
  parameter int WIN_LOG2 = 10
) (
  input  logic                clk_245,
  input  logic                asy_rst_n,
  input  logic                i_fram_hd,
  input  logic [29:0]         i_data,
  input  logic                i_data_valid,
  input  logic                i_ant8_sel,
  input  logic                i_clr,
  output logic                o_pwr_upd,
  output logic [2:0]          o_pwr_ant,
  output logic [29:0]         o_pwr,
  output logic [30*XNUM-1:0]  o_pwr_all,
  output logic [15*XNUM-1:0]  o_peak_all,
  output logic                o_sync_err
);
  localparam int                 c_ACC_W = 30 + WIN_LOG2;
  localparam int                 c_CNT_W = WIN_LOG2 + 1;
  localparam logic [c_CNT_W-1:0] c_WIN   = {1'b1, {WIN_LOG2{1'b0}}};
  localparam logic [c_CNT_W-1:0] c_ONE   = {{WIN_LOG2{1'b0}}, 1'b1};
  localparam logic [2:0]         c_LAST  = 3'(XNUM - 1);

  logic       r_first, r_sel_d, r_frz;
  logic [2:0] r_slot, w_cur;
  logic       w_wrap, w_resync, w_flush, w_accept;

  // r_slot holds the slot of the previous cycle; a header is aligned only after slot XNUM-1
  assign w_wrap   = (r_slot == c_LAST);
  assign w_cur    = (i_fram_hd || w_wrap) ? 3'd0 : r_slot + 3'd1;
  assign w_resync = i_fram_hd && !r_first && !w_wrap;
  assign w_flush  = w_resync || i_clr;
  assign w_accept = i_data_valid && (!w_cur[2] || (i_ant8_sel && !r_frz));

  always_ff @(posedge clk_245 or negedge asy_rst_n) begin
    if (!asy_rst_n) begin
      r_slot  <= 3'd0;
      r_first <= 1'b1;
      r_sel_d <= 1'b0;
      r_frz   <= 1'b0;
    end else begin
      r_slot  <= w_cur;
      r_sel_d <= i_ant8_sel;
      if (i_fram_hd) r_first <= 1'b0;
      if (r_sel_d && !i_ant8_sel) r_frz <= 1'b1;
      else if (w_flush)           r_frz <= 1'b0;
    end
  end

  logic        r_s1_vld, r_s2_vld;
  logic [14:0] r_s1_i, r_s1_q;
  logic [2:0]  r_s1_slot, r_s2_slot;
  logic [29:0] r_s2_sum, w_sum;
  logic signed [29:0] w_i_ext, w_q_ext, w_ii, w_qq;

  assign w_i_ext = {{15{r_s1_i[14]}}, r_s1_i};
  assign w_q_ext = {{15{r_s1_q[14]}}, r_s1_q};
  assign w_ii    = w_i_ext * w_i_ext;
  assign w_qq    = w_q_ext * w_q_ext;
  assign w_sum   = w_ii + w_qq;

  always_ff @(posedge clk_245 or negedge asy_rst_n) begin
    if (!asy_rst_n) begin
      r_s1_vld  <= 1'b0;
      r_s1_i    <= '0;
      r_s1_q    <= '0;
      r_s1_slot <= 3'd0;
      r_s2_vld  <= 1'b0;
      r_s2_sum  <= '0;
      r_s2_slot <= 3'd0;
    end else begin
      r_s1_vld  <= w_accept && !w_flush;
      r_s1_i    <= i_data[29:15];
      r_s1_q    <= i_data[14:0];
      r_s1_slot <= w_cur;
      r_s2_vld  <= r_s1_vld && !w_flush;
      r_s2_sum  <= w_sum;
      r_s2_slot <= r_s1_slot;
    end
  end

  logic [c_ACC_W-1:0] r_acc [XNUM];
  logic [c_CNT_W-1:0] r_cnt [XNUM];
  logic [c_ACC_W-1:0] w_acc_new;
  logic [c_CNT_W-1:0] w_cnt_new;
  logic               w_close;

  assign w_acc_new = r_acc[r_s2_slot] + {{WIN_LOG2{1'b0}}, r_s2_sum};
  assign w_cnt_new = r_cnt[r_s2_slot] + c_ONE;
  assign w_close   = r_s2_vld && (w_cnt_new == c_WIN);

  always_ff @(posedge clk_245 or negedge asy_rst_n) begin
    if (!asy_rst_n) begin
      for (int n = 0; n < XNUM; n++) begin
        r_acc[n] <= '0;
        r_cnt[n] <= '0;
      end
      o_pwr_upd  <= 1'b0;
      o_pwr_ant  <= 3'd0;
      o_pwr      <= '0;
      o_pwr_all  <= '0;
      o_sync_err <= 1'b0;
    end else begin
      o_pwr_upd  <= 1'b0;
      o_sync_err <= w_resync;
      if (w_flush) begin
        for (int n = 0; n < XNUM; n++) begin
          r_acc[n] <= '0;
          r_cnt[n] <= '0;
        end
        if (i_clr) begin
          o_pwr     <= '0;
          o_pwr_ant <= 3'd0;
          o_pwr_all <= '0;
        end
      end else if (w_close) begin
        r_acc[r_s2_slot] <= '0;
        r_cnt[r_s2_slot] <= '0;
        o_pwr_upd <= 1'b1;
        o_pwr_ant <= r_s2_slot;
        o_pwr     <= w_acc_new[c_ACC_W-1:WIN_LOG2];
        o_pwr_all[int'(r_s2_slot)*30 +: 30] <= w_acc_new[c_ACC_W-1:WIN_LOG2];
      end else if (r_s2_vld) begin
        r_acc[r_s2_slot] <= w_acc_new;
        r_cnt[r_s2_slot] <= w_cnt_new;
      end
    end
  end

`ifdef LTE_UL_AGC_PEAK_EN
  logic [14:0] w_abs_i, w_abs_q, r_s2_pk, w_pk_new;
  logic [14:0] r_pk [XNUM];

  // |-16384| = 16384 still fits the 15-bit unsigned magnitude
  assign w_abs_i  = r_s1_i[14] ? (~r_s1_i + 15'd1) : r_s1_i;
  assign w_abs_q  = r_s1_q[14] ? (~r_s1_q + 15'd1) : r_s1_q;
  assign w_pk_new = (r_s2_pk > r_pk[r_s2_slot]) ? r_s2_pk : r_pk[r_s2_slot];

  always_ff @(posedge clk_245 or negedge asy_rst_n) begin
    if (!asy_rst_n) begin
      r_s2_pk    <= '0;
      o_peak_all <= '0;
      for (int n = 0; n < XNUM; n++) r_pk[n] <= '0;
    end else begin
      r_s2_pk <= (w_abs_i > w_abs_q) ? w_abs_i : w_abs_q;
      if (w_flush) begin
        for (int n = 0; n < XNUM; n++) r_pk[n] <= '0;
        if (i_clr) o_peak_all <= '0;
      end else if (w_close) begin
        r_pk[r_s2_slot] <= '0;
        o_peak_all[int'(r_s2_slot)*15 +: 15] <= w_pk_new;
      end else if (r_s2_vld) begin
        r_pk[r_s2_slot] <= w_pk_new;
      end
    end
  end
`else
  assign o_peak_all = '0;
`endif

endmodule
`default_nettype wire

// File: doc/lte_ul_tdl_agc_pwr_meas.md
# lte_ul_tdl_agc_pwr_meas

Per-antenna mean-power meter for the uplink TDL path, placed directly after the uplink AGC stage. It consumes the 8-slot TDM, 15-bit I/Q AGC output stream (frame header, valid, 4/8-antenna select) and demultiplexes it by slot. For each antenna it accumulates I²+Q² over a fixed window and publishes the window mean. Software reads the results and writes the per-antenna AGC gain-index registers back, which closes the gain loop.

## Interface
Parameters:
- XNUM, 8, TDM slots (antennas) per frame period
- WIN_LOG2, 10, samples per antenna per measurement window = 2^WIN_LOG2

Ports:
- clk_245  in  1  system clock
- asy_rst_n  in  1  reset, asynchronous, active-low
- i_fram_hd  in  1  marks slot 0; the sample in the same cycle belongs to antenna 0
- i_data  in  30  {I[29:15], Q[14:0]}, two's complement
- i_data_valid  in  1  sample qualifier
- i_ant8_sel  in  1  1 = 8 antennas active; 0 = slots 4..7 ignored
- i_clr  in  1  synchronous clear of all accumulators, counts and results
- o_pwr_upd  out  1  one-cycle pulse when a window closes
- o_pwr_ant  out  3  antenna index of the closing window
- o_pwr  out  30  mean power of the closing window
- o_pwr_all  out  30*XNUM  latest mean per antenna, antenna n at [30n+29:30n]
- o_peak_all  out  15*XNUM  latest peak per antenna (see Configuration)
- o_sync_err  out  1  one-cycle pulse on a misaligned frame header

## Operation
- Slot counter, 3 bits:
  - i_fram_hd=1 loads 0.
  - Otherwise the counter increments every cycle and wraps from XNUM-1 to 0.
  - It runs regardless of valid.
- Misalignment: i_fram_hd=1 while the counter is not at XNUM-1 (and not the first header after reset) is a resync:
  - o_sync_err pulses.
  - All accumulators and sample counts clear.
  - In-flight pipeline samples are discarded.
  - o_pwr_all and o_peak_all are retained.
- A sample is accepted when i_data_valid=1 and (i_ant8_sel=1 or slot<4).
- Pipeline, three stages:
  - S1 registers I, Q, slot and the accept flag.
  - S2 computes I² and Q² (signed 15x15 to unsigned 29 bits) and sums them into 30 bits unsigned. The maximum is 2^29 at I=Q=-16384, so no overflow.
  - S3 adds the sum into acc[slot] (30+WIN_LOG2 bits) and increments cnt[slot] (WIN_LOG2+1 bits).
- Window close: when cnt[slot] reaches 2^WIN_LOG2 including the current sample:
  - o_pwr = acc[WIN_LOG2+29:WIN_LOG2], truncated.
  - o_pwr_all slice is updated to the same value.
  - o_pwr_ant = slot and o_pwr_upd=1.
  - acc and cnt for that slot clear.
- At most one window closes per cycle (TDM), so no arbitration is needed.
- i_ant8_sel falling to 0: counts and accumulators for slots 4..7 freeze and stay frozen until i_clr or resync. o_pwr_all slices 4..7 hold.
- i_clr: same effect as resync, and additionally zeroes o_pwr_all and o_peak_all. i_clr has priority over a simultaneous window close.

## Timing
- Reset values: o_pwr_upd=0, o_pwr_ant=0, o_pwr=0, o_pwr_all=0, o_peak_all=0, o_sync_err=0. Slot counter=0, first-header flag set.
- Latency: the closing sample accepted at input cycle t gives o_pwr_upd=1 and valid o_pwr/o_pwr_ant at cycle t+3. o_pwr_all updates in the same cycle.
- o_sync_err is asserted in the cycle after the offending i_fram_hd.
- A resync or i_clr at cycle t cancels every sample presented at cycles t-2..t. No o_pwr_upd is generated from those samples.
- Reset mid-window: all state returns to reset values immediately; no partial result is published.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- LTE_UL_AGC_PEAK_EN defined:
  - Per-antenna running peak max(|I|,|Q|), 15 bits unsigned (|-16384|=16384), tracked in S2/S3.
  - The peak is latched into o_peak_all at window close and reset with that window.
- Not defined: o_peak_all is tied to 0 and no peak logic is built.

## Test plan
- WIN_LOG2=2, 8 antennas, constant I=100, Q=-200, valid always -> every antenna closes after 4 samples with o_pwr=50000. Pulses arrive for ant 0..7 in consecutive cycles, 3 cycles after the 4th sample.
- All samples I=Q=-16384, WIN_LOG2=10 -> o_pwr=536870912 (2^29), no wrap.
- i_ant8_sel=0 with valid data in all slots -> only ant 0..3 pulse; o_pwr_all slices 4..7 stay 0.
- i_fram_hd asserted at slot 5 mid-window -> o_sync_err pulse; next closes occur 2^WIN_LOG2 accepted samples after realignment; previous o_pwr_all values are retained.
- i_clr in the cycle a window would close -> no o_pwr_upd, and o_pwr_all=0.
- With LTE_UL_AGC_PEAK_EN, antenna 2 sees I=-16384 once in a window, otherwise 0 -> o_peak_all[44:30]=16384. Without the macro -> 0.
